// File: rtl/image_loader.sv
// ----------------------------------------------------------------------------
// image_loader
//
// Purpose:
//   Byte-serial front end for the network top level. A frame consists of one
//   header byte (selects forward-only or training pass), one label byte and
//   NPIX pixel bytes. Every pixel is widened to PW bits and left-shifted by
//   SHIFT to form a fixed-point value. Once the last pixel is stored, the
//   loader issues a one-cycle start_fp or start_bp pulse. It then refuses
//   further bytes until the network signals done, which keeps image_out and
//   label_out stable for the whole pass.
//
// Ports:
//   clk         in   1          system clock
//   rst         in   1          synchronous reset, active-high
//   byte_valid  in   1          byte_data holds a valid byte
//   byte_data   in   8          frame byte
//   byte_ready  out  1          loader accepts a byte this cycle
//   done        in   1          network finished current pass (level or pulse)
//   image_out   out  NPIX*PW    packed [NPIX-1:0][PW-1:0] scaled image
//   label_out   out  8          label byte of current frame
//   start_fp    out  1          one-cycle pulse: run forward pass
//   start_bp    out  1          one-cycle pulse: run training pass
//   busy        out  1          frame in progress or network running
//   hdr_err     out  1          one-cycle pulse: bad header byte dropped
// ----------------------------------------------------------------------------
module image_loader #(
  parameter int         NPIX   = 784,
  parameter int         PW     = 32,
  parameter int         SHIFT  = 9,
  parameter logic [7:0] HDR_FP = 8'hA0,
  parameter logic [7:0] HDR_BP = 8'hA1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  input  logic                 done,
  output logic [NPIX*PW-1:0]   image_out,
  output logic [7:0]           label_out,
  output logic                 start_fp,
  output logic                 start_bp,
  output logic                 busy,
  output logic                 hdr_err
);

  localparam int            CW       = $clog2(NPIX);
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LABEL     = 3'd1;
  localparam logic [2:0] S_PIXELS    = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  // Widen an 8-bit pixel to PW bits and apply the fixed-point scale.
  // Bits shifted beyond PW are discarded (truncation, no saturation).
  function automatic logic [PW-1:0] scale_pix(input logic [7:0] b);
    logic [PW-1:0] w;
    w      = '0;
    w[7:0] = b;
    return w << SHIFT;
  endfunction

  logic [2:0]                r_state;
  logic [CW-1:0]             r_pix_cnt;
  logic                      r_mode_bp;
  logic                      r_start_fp;
  logic                      r_start_bp;
  logic                      r_hdr_err;
  logic [7:0]                r_label;
  logic [NPIX-1:0][PW-1:0]   r_image;

  logic                      w_ready;
  logic                      w_take;
  logic                      w_hdr_ok;

  // Only the three byte-consuming states accept data; START and WAIT_DONE
  // apply backpressure so the stored frame cannot change under the network.
  assign w_ready  = (r_state == S_IDLE) || (r_state == S_LABEL) ||
                    (r_state == S_PIXELS);
  assign w_take   = byte_valid && w_ready;
  assign w_hdr_ok = (byte_data == HDR_FP) || (byte_data == HDR_BP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pix_cnt  <= '0;
      r_mode_bp  <= 1'b0;
      r_start_fp <= 1'b0;
      r_start_bp <= 1'b0;
      r_hdr_err  <= 1'b0;
      r_label    <= 8'h00;
      r_image    <= '0;
    end else begin
      // Pulse outputs default low; they are raised for a single cycle only.
      r_start_fp <= 1'b0;
      r_start_bp <= 1'b0;
      r_hdr_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            if (w_hdr_ok) begin
              r_mode_bp <= (byte_data == HDR_BP);
              r_state   <= S_LABEL;
            end else begin
              r_hdr_err <= 1'b1;
            end
          end
        end

        S_LABEL: begin
          if (w_take) begin
            r_label   <= byte_data;
            r_pix_cnt <= '0;
            r_state   <= S_PIXELS;
          end
        end

        S_PIXELS: begin
          if (w_take) begin
            r_image[r_pix_cnt] <= scale_pix(byte_data);
            if (r_pix_cnt == LAST_PIX) begin
              // Counter is left at the last index rather than wrapping; it
              // is cleared again when the next label arrives. The start
              // pulse is registered here so it is high exactly during START.
              r_start_fp <= ~r_mode_bp;
              r_start_bp <= r_mode_bp;
              r_state    <= S_START;
            end else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
            end
          end
        end

        // done is deliberately not examined here: a done left over from the
        // previous pass must not end the pass that is only now starting.
        S_START: begin
          r_state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (done) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready = w_ready;
  assign busy       = (r_state != S_IDLE);
  assign start_fp   = r_start_fp;
  assign start_bp   = r_start_bp;
  assign hdr_err    = r_hdr_err;
  assign label_out  = r_label;
  assign image_out  = r_image;

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;

  localparam int NPIX = 784;
  localparam int PW   = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                byte_valid = 1'b0;
  logic [7:0]          byte_data = 8'h00;
  logic                byte_ready;
  logic                done = 1'b0;
  logic [NPIX*PW-1:0]  image_out;
  logic [7:0]          label_out;
  logic                start_fp;
  logic                start_bp;
  logic                busy;
  logic                hdr_err;

  image_loader dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .done       (done),
    .image_out  (image_out),
    .label_out  (label_out),
    .start_fp   (start_fp),
    .start_bp   (start_bp),
    .busy       (busy),
    .hdr_err    (hdr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: tracks position within the frame as a byte index
  // (0 = header expected, 1 = label expected, 2.. = pixel bytes),
  // plus whether a pass has been launched and is awaiting done.
  // ------------------------------------------------------------------
  bit                     m_on = 1'b0;
  int                     m_pos;
  bit                     m_wait;
  bit                     m_start;
  bit                     m_err;
  bit                     m_bp;
  logic [7:0]             m_label;
  logic [NPIX-1:0][31:0]  m_img;

  always @(posedge clk) begin
    bit         nstart;
    bit         nerr;
    logic [31:0] v;
    if (rst) begin
      m_on    = 1'b1;
      m_pos   = 0;
      m_wait  = 1'b0;
      m_start = 1'b0;
      m_err   = 1'b0;
      m_bp    = 1'b0;
      m_label = 8'h00;
      m_img   = '0;
    end else if (m_on) begin
      nstart = 1'b0;
      nerr   = 1'b0;
      if (m_start) begin
        m_wait = 1'b1;
      end else if (m_wait) begin
        if (done) m_wait = 1'b0;
      end else if (byte_valid) begin
        if (m_pos == 0) begin
          if (byte_data == 8'hA0 || byte_data == 8'hA1) begin
            m_bp  = (byte_data == 8'hA1);
            m_pos = 1;
          end else begin
            nerr = 1'b1;
          end
        end else if (m_pos == 1) begin
          m_label = byte_data;
          m_pos   = 2;
        end else begin
          v = 32'(byte_data) * 512;
          m_img[m_pos-2] = v;
          m_pos++;
          if (m_pos == NPIX + 2) begin
            m_pos  = 0;
            nstart = 1'b1;
          end
        end
      end
      m_start = nstart;
      m_err   = nerr;
    end
  end

  // Compare process and pulse counters, on the inactive edge.
  int cnt_fp  = 0;
  int cnt_bp  = 0;
  int cnt_err = 0;

  always @(negedge clk) begin
    if (m_on && !rst) begin
      chk("byte_ready", byte_ready, !m_wait && !m_start);
      chk("busy", busy, (m_pos != 0) || m_wait || m_start);
      chk("start_fp", start_fp, m_start && !m_bp);
      chk("start_bp", start_bp, m_start && m_bp);
      chk("hdr_err", hdr_err, m_err);
      chk("label_out", label_out, m_label);
      checks++;
      if (image_out !== m_img) begin
        errors++;
        for (int k = 0; k < NPIX; k++) begin
          if (image_out[k*PW +: PW] !== m_img[k]) begin
            $display("FAIL image_out word %0d got %0h expected %0h",
                     k, image_out[k*PW +: PW], m_img[k]);
            break;
          end
        end
      end
    end
    if (start_fp) cnt_fp++;
    if (start_bp) cnt_bp++;
    if (hdr_err)  cnt_err++;
  end

  // ------------------------------------------------------------------
  // Stimulus helpers. All tasks start and end 1 time unit after a rising
  // edge, so inputs change away from the sampling edge.
  // ------------------------------------------------------------------
  logic [7:0] pix [NPIX];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int tmo;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      cyc();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    tmo = 0;
    while (!byte_ready && tmo < 1000) begin
      cyc();
      tmo++;
    end
    if (tmo >= 1000) begin
      errors++;
      $display("FAIL send_byte timeout got ready=%0b required 1", byte_ready);
    end
    cyc();
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] lbl,
                            input int npx, input int gap_pct);
    send_byte(hdr, gap_pct);
    send_byte(lbl, gap_pct);
    for (int i = 0; i < npx; i++) send_byte(pix[i], gap_pct);
  endtask

  // Entered during the START cycle; ends one cycle after done is seen.
  task automatic finish_pass(input bit done_in_start, input int hold, input bit noise);
    if (done_in_start) done = 1'b1;
    cyc();
    done = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
      end
      cyc();
      chk("wait_ready_low", byte_ready, 1'b0);
      chk("wait_busy", busy, 1'b1);
    end
    done = 1'b1;
    cyc();
    done       = 1'b0;
    byte_valid = 1'b0;
    chk("ready_after_done", byte_ready, 1'b1);
  endtask

  int s0;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", byte_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_label", label_out, 8'h00);
    chk("rst_img0", image_out[0 +: PW], 32'h0);

    // Forward pass, all pixels 0x01, done asserted during START (ignored).
    for (int i = 0; i < NPIX; i++) pix[i] = 8'h01;
    send_frame(8'hA0, 8'h07, NPIX, 0);
    chk("t1_start_fp", start_fp, 1'b1);
    chk("t1_start_bp", start_bp, 1'b0);
    finish_pass(1'b1, 5, 1'b0);
    chk("t1_img0", image_out[0*PW +: PW], 32'h200);
    chk("t1_img400", image_out[400*PW +: PW], 32'h200);
    chk("t1_img783", image_out[783*PW +: PW], 32'h200);
    chk("t1_label", label_out, 8'h07);
    chk("t1_fp_count", cnt_fp, 1);
    chk("t1_bp_count", cnt_bp, 0);

    // Training pass, ramp pattern, noisy bytes offered while waiting for done.
    for (int i = 0; i < NPIX; i++) pix[i] = 8'(i);
    send_frame(8'hA1, 8'h03, NPIX, 0);
    chk("t2_start_bp", start_bp, 1'b1);
    chk("t2_start_fp", start_fp, 1'b0);
    finish_pass(1'b0, 20, 1'b1);
    chk("t2_img255", image_out[255*PW +: PW], 32'h1FE00);
    chk("t2_img256", image_out[256*PW +: PW], 32'h0);
    chk("t2_img1", image_out[1*PW +: PW], 32'h200);
    chk("t2_label", label_out, 8'h03);
    chk("t2_bp_count", cnt_bp, 1);
    chk("t2_fp_count", cnt_fp, 1);

    // Bad header then a valid frame.
    s0 = cnt_err;
    send_byte(8'h5A, 0);
    chk("t4_hdr_err", hdr_err, 1'b1);
    chk("t4_busy", busy, 1'b0);
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    send_frame(8'hA0, 8'h42, NPIX, 0);
    finish_pass(1'b0, 3, 1'b0);
    chk("t4_err_count", cnt_err - s0, 1);
    chk("t4_label", label_out, 8'h42);

    // Reset after 400 pixels, then a complete frame.
    s0 = cnt_fp + cnt_bp;
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    send_frame(8'hA1, 8'h09, 400, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    chk("t5_no_start", cnt_fp + cnt_bp - s0, 0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_label", label_out, 8'h00);
    send_frame(8'hA0, 8'h0B, NPIX, 0);
    finish_pass(1'b0, 4, 1'b0);
    chk("t5_one_start", cnt_fp + cnt_bp - s0, 1);

    // done pulsed while idle, then frames with randomly gapped valid.
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
    chk("t6_idle_busy", busy, 1'b0);
    chk("t6_idle_ready", byte_ready, 1'b1);
    s0 = cnt_bp;
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    send_frame(8'hA1, 8'($urandom), NPIX, 50);
    finish_pass(1'b0, 2, 1'b1);
    send_frame(8'hA0, 8'h55, NPIX, 50);
    finish_pass(1'b1, 3, 1'b0);
    chk("t6_bp_count", cnt_bp - s0, 1);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
